// File: rtl/hazard_flush_scheduler.sv
// hazard_flush_scheduler: prioritized pipeline hazard/redirect/interrupt sequencer.
// Ports: clk, reset (async active-low); events load_use, uncond_jump, branch_taken,
// mem_busy, int_req; controls pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
// pipe_freeze, pc_sel (00 pc+1, 01 jump, 10 branch, 11 vector), int_ack.
module hazard_flush_scheduler #(
  parameter int LU_STALLS    = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_use,
  input  logic       uncond_jump,
  input  logic       branch_taken,
  input  logic       mem_busy,
  input  logic       int_req,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_freeze,
  output logic [1:0] pc_sel,
  output logic       int_ack
);
  typedef enum logic [1:0] {RUN, LU_STALL, INT_DRAIN, INT_VECTOR} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    pipe_freeze    = 1'b0;
    pc_sel         = 2'b00;
    int_ack        = 1'b0;
    state_n        = state;
    cnt_n          = cnt;
    if (!reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
    end else if (mem_busy) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      pipe_freeze    = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            pc_sel      = 2'b10;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (uncond_jump) begin
            pc_sel      = 2'b01;
            if_id_flush = 1'b1;
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            if (LU_STALLS > 1) begin
              state_n = LU_STALL;
              cnt_n   = 4'(LU_STALLS - 1);
            end
          end else if (int_req) begin
            state_n = INT_DRAIN;
            cnt_n   = 4'(DRAIN_CYCLES);
          end
        end
        LU_STALL: begin
          if (branch_taken) begin
            pc_sel      = 2'b10;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_n     = RUN;
            cnt_n       = '0;
          end else begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            cnt_n          = cnt - 4'd1;
            state_n        = (cnt == 4'd1) ? RUN : LU_STALL;
          end
        end
        INT_DRAIN: begin
          // redirects still update PC so the saved return address is correct
          if (branch_taken) begin
            pc_sel      = 2'b10;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (uncond_jump) begin
            pc_sel      = 2'b01;
            if_id_flush = 1'b1;
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
          end else begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
          end
          cnt_n   = cnt - 4'd1;
          state_n = (cnt == 4'd1) ? INT_VECTOR : INT_DRAIN;
        end
        default: begin
          pc_sel      = 2'b11;
          if_id_flush = 1'b1;
          int_ack     = 1'b1;
          state_n     = RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_flush_scheduler.sv
// tb_hazard_flush_scheduler: directed plus random checks against a counter-based reference model.
module tb_hazard_flush_scheduler;
  localparam int LU = 2;
  localparam int DR = 3;
  localparam logic [7:0] E_RST = 8'b0011_0000;
  localparam logic [7:0] E_DFL = 8'b1100_0000;
  localparam logic [7:0] E_FRZ = 8'b0000_1000;
  localparam logic [7:0] E_BR  = 8'b1111_0100;
  localparam logic [7:0] E_JMP = 8'b1110_0010;
  localparam logic [7:0] E_STL = 8'b0001_0000;
  localparam logic [7:0] E_DRN = 8'b0110_0000;
  localparam logic [7:0] E_VEC = 8'b1110_0111;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_use = 1'b0, uncond_jump = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0, int_req = 1'b0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, pipe_freeze, int_ack;
  logic [1:0] pc_sel;
  logic [7:0] obs;
  int n_cmp = 0, n_err = 0;
  int lu_rem = 0, drain_rem = 0;
  bit vec = 1'b0;
  int acks = 0;
  hazard_flush_scheduler #(.LU_STALLS(LU), .DRAIN_CYCLES(DR)) dut (
    .clk(clk), .reset(reset), .load_use(load_use), .uncond_jump(uncond_jump),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .pc_sel(pc_sel), .int_ack(int_ack)
  );
  always #5 clk = ~clk;
  assign obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, pipe_freeze, pc_sel, int_ack};
  task automatic step(input string tag, input bit rs, input bit mb, input bit br, input bit jmp, input bit lu, input bit ir);
    logic [7:0] e;
    int nl, nd;
    bit nv;
    reset = rs; mem_busy = mb; branch_taken = br; uncond_jump = jmp; load_use = lu; int_req = ir;
    nl = lu_rem; nd = drain_rem; nv = vec;
    if (!rs) begin
      e = E_RST; nl = 0; nd = 0; nv = 1'b0;
    end else if (mb) e = E_FRZ;
    else if (vec) begin
      e = E_VEC; nv = 1'b0;
    end else if (drain_rem > 0) begin
      e = br ? E_BR : jmp ? E_JMP : lu ? E_STL : E_DRN;
      nd = drain_rem - 1;
      nv = (nd == 0);
    end else if (lu_rem > 0) begin
      e = br ? E_BR : E_STL;
      nl = br ? 0 : lu_rem - 1;
    end else begin
      e = br ? E_BR : jmp ? E_JMP : lu ? E_STL : E_DFL;
      if (!br && !jmp && lu) nl = LU - 1;
      else if (!br && !jmp && !lu && ir) nd = DR;
    end
    @(negedge clk);
    n_cmp++;
    if (int_ack === 1'b1) acks++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, e);
    end
    @(posedge clk);
    lu_rem = nl; drain_rem = nd; vec = nv;
    #1;
  endtask
  initial begin
    @(posedge clk); #1;
    repeat (3) step("reset_hold", 0, 0, 0, 0, 0, 0);
    n_cmp++;
    assert (obs === E_RST) else begin
      n_err++;
      $error("FAIL reset_const obs=%b exp=%b", obs, E_RST);
    end
    step("post_reset", 1, 0, 0, 0, 0, 0);
    step("lu1", 1, 0, 0, 0, 1, 0);
    repeat (3) step("lu1_tail", 1, 0, 0, 0, 0, 0);
    step("lu_br_a", 1, 0, 0, 0, 1, 0);
    step("lu_br_b", 1, 0, 1, 0, 0, 0);
    repeat (2) step("lu_br_tail", 1, 0, 0, 0, 0, 0);
    step("br_jmp", 1, 0, 1, 1, 0, 0);
    step("jmp", 1, 0, 0, 1, 0, 0);
    step("idle", 1, 0, 0, 0, 0, 0);
    step("lu_mb", 1, 0, 0, 0, 1, 0);
    repeat (4) step("mb_freeze", 1, 1, 0, 0, 1, 0);
    repeat (3) step("mb_tail", 1, 0, 0, 0, 0, 0);
    acks = 0;
    step("int_acc", 1, 0, 0, 0, 0, 1);
    repeat (5) step("int_seq", 1, 0, 0, 0, 0, 0);
    n_cmp++;
    assert (acks === 1) else begin
      n_err++;
      $error("FAIL int_ack_count obs=%0d exp=1", acks);
    end
    acks = 0;
    step("int_br_acc", 1, 0, 0, 0, 0, 1);
    step("int_br_d1", 1, 0, 0, 0, 0, 0);
    step("int_br_d2", 1, 0, 1, 0, 0, 0);
    step("int_br_d3", 1, 0, 0, 0, 0, 0);
    step("int_br_vec", 1, 0, 0, 0, 0, 0);
    step("int_br_tail", 1, 0, 0, 0, 0, 0);
    n_cmp++;
    assert (acks === 1) else begin
      n_err++;
      $error("FAIL int_br_ack_count obs=%0d exp=1", acks);
    end
    acks = 0;
    step("int_rst_acc", 1, 0, 0, 0, 0, 1);
    step("int_rst_d1", 1, 0, 0, 0, 0, 0);
    repeat (2) step("int_rst_low", 0, 0, 0, 0, 0, 0);
    repeat (5) step("int_rst_tail", 1, 0, 0, 0, 0, 0);
    n_cmp++;
    assert (acks === 0) else begin
      n_err++;
      $error("FAIL int_rst_ack_count obs=%0d exp=0", acks);
    end
    for (int i = 0; i < 600; i++)
      step("random", $urandom_range(99) >= 2, $urandom_range(99) < 15, $urandom_range(99) < 10,
           $urandom_range(99) < 10, $urandom_range(99) < 15, $urandom_range(99) < 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_flush_scheduler.md
Name: hazard_flush_scheduler

Overview:
- Central pipeline-control scheduler, decode stage.
- Takes hazard/redirect events (load-use, unconditional jump, taken branch, memory busy, interrupt request) and sequences PC write-enable, IF/ID write/flush, ID/EX flush and PC source select.
- Replaces per-event ad-hoc flush logic with one prioritized FSM. Also owns the interrupt drain/vector sequence.

Parameters:
- LU_STALLS, 1, bubble cycles inserted per load-use hazard (1..7).
- DRAIN_CYCLES, 3, cycles fetch is held before vectoring on interrupt (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_use  in  1  decode detects load in EX whose dest matches an ID source.
- uncond_jump  in  1  unconditional jump decoded in ID.
- branch_taken  in  1  conditional branch resolved taken in EX.
- mem_busy  in  1  memory stage multi-cycle access in progress.
- int_req  in  1  level interrupt request.
- pc_write_en  out  1  PC register load enable.
- if_id_write_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_flush  out  1  ID/EX loads NOP (bubble).
- pipe_freeze  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- pc_sel  out  2  00 PC+1, 01 jump target, 10 branch target, 11 interrupt vector.
- int_ack  out  1  one-cycle pulse, vector taken.

Behaviour:
- Async reset (reset=0): state=RUN, counters=0. Outputs forced while low: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_flush=1, pipe_freeze=0, pc_sel=00, int_ack=0. First rising edge after release behaves as RUN.
- Outputs are combinational from state+inputs. State and counters are registered.
- States: RUN, LU_STALL, INT_DRAIN, INT_VECTOR.
- Default (RUN, no event): pc_write_en=1, if_id_write_en=1, flushes=0, pipe_freeze=0, pc_sel=00.
- Priority per cycle, highest first: mem_busy > branch_taken > uncond_jump > load_use > int_req.
- mem_busy=1, any state:
  - pc_write_en=0, if_id_write_en=0, pipe_freeze=1, flushes=0.
  - State and counters hold. Lower events are ignored; they stay asserted because stages are frozen.
- branch_taken (RUN, LU_STALL or INT_DRAIN):
  - pc_sel=10, pc_write_en=1, if_id_flush=1, id_ex_flush=1.
  - LU_STALL -> RUN, counter cleared. INT_DRAIN continues, counter decrements.
- uncond_jump (RUN or INT_DRAIN):
  - pc_sel=01, pc_write_en=1, if_id_flush=1, id_ex_flush=0.
  - Single-cycle, no state change.
- load_use in RUN:
  - pc_write_en=0, if_id_write_en=0, id_ex_flush=1.
  - If LU_STALLS>1: -> LU_STALL with counter=LU_STALLS-1.
- LU_STALL:
  - Same outputs as load_use in RUN. Counter decrements each non-frozen cycle.
  - Counter reaching 0 -> RUN. load_use is ignored in this state.
- int_req in RUN, no higher event this cycle:
  - Accepted. -> INT_DRAIN, counter=DRAIN_CYCLES.
  - The acceptance cycle itself behaves as default.
- INT_DRAIN:
  - Outputs: pc_write_en=0, if_id_write_en=1, if_id_flush=1 (fetch bubbles), id_ex_flush=0.
  - Exceptions: branch/jump redirect as above, so the PC holds the correct return address. load_use produces its stall outputs for that cycle.
  - Counter decrements each non-frozen cycle. At 0 -> INT_VECTOR.
- INT_VECTOR (one cycle): pc_sel=11, pc_write_en=1, if_id_flush=1, int_ack=1, then -> RUN.
  - int_req ignored in INT_DRAIN/INT_VECTOR. Must deassert on int_ack, or it is re-accepted.
- Simultaneous branch_taken+uncond_jump: branch wins (older instruction). The jump is flushed with ID.
- Reset mid-sequence (any state): immediate return to RUN, no int_ack.

Test Plan:
- Reset low 3 cycles, release: during reset if_id_flush=id_ex_flush=1, pc_write_en=0. First cycle after release: pc_write_en=1, pc_sel=00.
- load_use=1 one cycle, LU_STALLS=2: pc_write_en=0 and id_ex_flush=1 for exactly 2 cycles, then default. Repeat with branch_taken in 2nd cycle: that cycle pc_sel=10, both flushes=1, RUN next.
- uncond_jump and branch_taken same cycle -> pc_sel=10, if_id_flush=1, id_ex_flush=1. uncond_jump alone -> pc_sel=01, id_ex_flush=0.
- mem_busy=1 for 4 cycles during LU_STALL (counter=1): pipe_freeze=1 for 4 cycles, counter held. Stall completes 1 cycle after mem_busy drops.
- int_req=1 in RUN, DRAIN_CYCLES=3: acceptance cycle default, 3 cycles if_id_flush=1 with pc_write_en=0, then int_ack=1 with pc_sel=11 for exactly 1 cycle.
- int_req accepted, branch_taken in 2nd drain cycle: that cycle pc_sel=10, pc_write_en=1. int_ack still occurs on the same cycle as without the branch. Assert reset mid-drain -> no int_ack, RUN after release.
